pe_tile_scheduler: RTL and testbench

- Sequences one sparse PE over a grid of IA x W tiles: requests each bundle load, pulses the PE start, waits for PE finish, then drains the feature-map rows to the output buffer.
- Sits between the top-level layer controller (start/iteration counts) and the PE plus its IA/W bundle buffers and feature-map writeback buffer.

---
 rtl/pe_tile_scheduler.sv | 134 +++++++++++++
 tb/tb_pe_tile_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_scheduler.sv
`default_nettype none
// ============================================================================
// pe_tile_scheduler : walks one sparse PE over an IA x W tile grid
//                     (load bundles, start PE, wait finish, drain fmap rows).
// Revision: 1.0
// ============================================================================
module pe_tile_scheduler #(
  parameter int ITER_W = 6,
  parameter int ROW    = 16,
  parameter int ROW_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ITER_W-1:0] i_ia_iters,
  input  logic [ITER_W-1:0] i_w_iters,
  output logic              o_load_valid,
  output logic [ITER_W-1:0] o_load_ia_idx,
  output logic [ITER_W-1:0] o_load_w_idx,
  input  logic              i_load_ready,
  input  logic              i_load_done,
  output logic              o_pe_start,
  input  logic              i_pe_finish,
  output logic              o_wb_valid,
  output logic [ROW_W-1:0]  o_wb_row,
  input  logic              i_wb_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REQ  = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_RUN       = 3'd3,
    S_WAIT_PE   = 3'd4,
    S_WB        = 3'd5,
    S_NEXT      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROW - 1);
  localparam logic [ITER_W-1:0] ONE      = ITER_W'(1);

  state_t            state_q, state_d;
  logic [ITER_W-1:0] ia_iters_q, ia_iters_d;
  logic [ITER_W-1:0] w_iters_q, w_iters_d;
  logic [ITER_W-1:0] ia_idx_q, ia_idx_d;
  logic [ITER_W-1:0] w_idx_q, w_idx_d;
  logic [ROW_W-1:0]  row_q, row_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ia_iters_q <= '0;
      w_iters_q  <= '0;
      ia_idx_q   <= '0;
      w_idx_q    <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      ia_iters_q <= ia_iters_d;
      w_iters_q  <= w_iters_d;
      ia_idx_q   <= ia_idx_d;
      w_idx_q    <= w_idx_d;
      row_q      <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ia_iters_d = ia_iters_q;
    w_iters_d  = w_iters_q;
    ia_idx_d   = ia_idx_q;
    w_idx_d    = w_idx_q;
    row_d      = row_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          ia_iters_d = i_ia_iters;
          w_iters_d  = i_w_iters;
          ia_idx_d   = '0;
          w_idx_d    = '0;
          state_d    = ((i_ia_iters == '0) || (i_w_iters == '0)) ? S_DONE : S_LOAD_REQ;
        end
      end
      S_LOAD_REQ:  if (i_load_ready) state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: if (i_load_done)  state_d = S_RUN;
      // Finish is deliberately not looked at here: a level left over from the
      // previous tile must not bypass the WAIT_PE handshake.
      S_RUN:       state_d = S_WAIT_PE;
      S_WAIT_PE: begin
        if (i_pe_finish) begin
          row_d   = '0;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (i_wb_ready) begin
          row_d = row_q + 1'b1;
          if (row_q == LAST_ROW) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // iters are non-zero here, so iters-1 cannot underflow
        if (ia_idx_q < (ia_iters_q - ONE)) begin
          ia_idx_d = ia_idx_q + ONE;
          state_d  = S_LOAD_REQ;
        end else begin
          ia_idx_d = '0;
          if (w_idx_q < (w_iters_q - ONE)) begin
            w_idx_d = w_idx_q + ONE;
            state_d = S_LOAD_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_load_valid  = (state_q == S_LOAD_REQ);
  assign o_load_ia_idx = ia_idx_q;
  assign o_load_w_idx  = w_idx_q;
  assign o_pe_start    = (state_q == S_RUN);
  assign o_wb_valid    = (state_q == S_WB);
  assign o_wb_row      = row_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pe_tile_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pe_tile_scheduler : directed + randomized bench with a tile-order model.
// Revision: 1.0
// ============================================================================
module tb_pe_tile_scheduler;
  localparam int ITER_W = 6;
  localparam int ROW    = 16;
  localparam int ROW_W  = 4;

  localparam int M_IMM    = 0;  // all handshakes immediate
  localparam int M_RAND   = 1;  // random ready/done/finish
  localparam int M_FINHI  = 2;  // pe_finish held high
  localparam int M_WBTOG  = 3;  // wb_ready 1,0,0,1 pattern + stray start
  localparam int M_STALL  = 4;  // load_ready stalled 4 cycles
  localparam int M_RESET  = 5;  // reset at WB row 7

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ITER_W-1:0] ia_iters = '0;
  logic [ITER_W-1:0] w_iters = '0;
  logic              load_valid;
  logic [ITER_W-1:0] load_ia_idx;
  logic [ITER_W-1:0] load_w_idx;
  logic              load_ready = 1'b0;
  logic              load_done = 1'b0;
  logic              pe_start;
  logic              pe_finish = 1'b0;
  logic              wb_valid;
  logic [ROW_W-1:0]  wb_row;
  logic              wb_ready = 1'b0;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;
  int rel;

  always #5 clk = ~clk;

  pe_tile_scheduler #(.ITER_W(ITER_W), .ROW(ROW), .ROW_W(ROW_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_ia_iters(ia_iters), .i_w_iters(w_iters),
    .o_load_valid(load_valid), .o_load_ia_idx(load_ia_idx), .o_load_w_idx(load_w_idx),
    .i_load_ready(load_ready), .i_load_done(load_done),
    .o_pe_start(pe_start), .i_pe_finish(pe_finish),
    .o_wb_valid(wb_valid), .o_wb_row(wb_row), .i_wb_ready(wb_ready),
    .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load_valid"}, 32'(load_valid), 0);
    chk({tag, "_pe_start"},   32'(pe_start), 0);
    chk({tag, "_wb_valid"},   32'(wb_valid), 0);
    chk({tag, "_busy"},       32'(busy), 0);
    chk({tag, "_done"},       32'(done), 0);
    chk({tag, "_ia_idx"},     32'(load_ia_idx), 0);
    chk({tag, "_w_idx"},      32'(load_w_idx), 0);
    chk({tag, "_wb_row"},     32'(wb_row), 0);
  endtask

  // One job: the model is the nested tile loop (W outer, IA inner), ROW rows
  // per tile, and exactly one done at the end.
  task automatic run_job(input int ia, input int w, input int mode, output int done_rel);
    int  q_ia[$];
    int  q_w[$];
    int  tiles, exp_row, pe_cnt, wb_cnt, hs_cnt, done_cnt, first_load, since_pe;
    int  stall_left, wbphase, stalls_seen;
    bit  prev_lv_stall, prev_wb_stall, prev_wb, stray_sent;
    for (int wi = 0; wi < w; wi++)
      for (int ii = 0; ii < ia; ii++) begin
        q_ia.push_back(ii);
        q_w.push_back(wi);
      end
    tiles = ia * w;
    exp_row = 0; pe_cnt = 0; wb_cnt = 0; hs_cnt = 0; done_cnt = 0;
    first_load = -1; since_pe = 100; stall_left = 4; wbphase = 0; stalls_seen = 0;
    prev_lv_stall = 0; prev_wb_stall = 0; prev_wb = 0; stray_sent = 0;
    done_rel = -1;

    @(posedge clk); #1;
    start = 1'b1; ia_iters = ITER_W'(ia); w_iters = ITER_W'(w);
    @(posedge clk); #1;
    start = 1'b0;
    ia_iters = ITER_W'($urandom_range(1, 63));
    w_iters  = ITER_W'($urandom_range(1, 63));

    for (int cyc = 0; cyc < 6000; cyc++) begin
      // drive this cycle's inputs
      start      = 1'b0;
      load_ready = (mode == M_IMM || mode == M_RESET) ? 1'b1 : ($urandom_range(0, 3) != 0);
      load_done  = (mode == M_IMM || mode == M_RESET) ? 1'b1 : ($urandom_range(0, 2) == 0);
      pe_finish  = (mode == M_IMM || mode == M_RESET || mode == M_FINHI) ? 1'b1
                                                                         : ($urandom_range(0, 3) == 0);
      wb_ready   = (mode == M_IMM || mode == M_RESET) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (mode == M_STALL && load_valid && stall_left > 0) begin
        load_ready = 1'b0;
        load_done  = (stall_left == 2);
        stall_left--;
      end
      if (mode == M_WBTOG && wb_valid) begin
        wb_ready = (wbphase % 4 == 0) || (wbphase % 4 == 3);
        wbphase++;
        if (!stray_sent && exp_row == 5) begin
          start = 1'b1; ia_iters = 7; w_iters = 7; stray_sent = 1;
        end
      end

      @(negedge clk);
      if (mode == M_RESET && wb_valid && exp_row == 7) begin
        chk("rst_row7_seen", 32'(wb_row), 7);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk); #1;
        chk_all_zero("rst_held");
        rst = 1'b0;
        return;
      end

      if (prev_lv_stall) chk("load_valid_hold", 32'(load_valid), 1);
      if (prev_wb_stall) chk("wb_valid_hold", 32'(wb_valid), 1);
      if (load_valid) begin
        if (first_load < 0) first_load = cyc;
        if (q_ia.size() > 0) begin
          chk("load_ia_idx", 32'(load_ia_idx), 32'(q_ia[0]));
          chk("load_w_idx",  32'(load_w_idx),  32'(q_w[0]));
        end else begin
          chk("load_extra", 32'(load_valid), 0);
        end
        if (load_ready) begin
          if (q_ia.size() > 0) begin
            void'(q_ia.pop_front());
            void'(q_w.pop_front());
          end
          hs_cnt++;
        end else begin
          stalls_seen++;
        end
      end
      prev_lv_stall = load_valid && !load_ready;

      if (pe_start) begin
        pe_cnt++;
        since_pe = 0;
      end else begin
        since_pe++;
      end
      if (mode == M_FINHI && since_pe == 2) chk("wb_two_after_run", 32'(wb_valid), 1);

      if (wb_valid) begin
        if (!prev_wb) chk("pe_start_before_wb", 32'(pe_cnt), 32'(wb_cnt / ROW + 1));
        chk("wb_row", 32'(wb_row), 32'(exp_row));
        if (wb_ready) begin
          exp_row = (exp_row + 1) % ROW;
          wb_cnt++;
        end
      end
      prev_wb = wb_valid;
      prev_wb_stall = wb_valid && !wb_ready;

      chk("busy_in_job", 32'(busy), 1);
      if (done) begin
        done_cnt++;
        done_rel = cyc - first_load;
        break;
      end
      @(posedge clk); #1;
    end

    chk("done_seen",     32'(done_cnt), 1);
    chk("handshakes",    32'(hs_cnt), 32'(tiles));
    chk("loads_left",    32'(q_ia.size()), 0);
    chk("pe_starts",     32'(pe_cnt), 32'(tiles));
    chk("wb_rows_total", 32'(wb_cnt), 32'(tiles * ROW));
    if (mode == M_STALL) chk("stall_cycles", 32'(stalls_seen >= 4), 1);
    @(posedge clk); #1;
    chk("idle_after_done_busy", 32'(busy), 0);
    chk("idle_after_done_done", 32'(done), 0);
    load_ready = 0; load_done = 0; pe_finish = 0; wb_ready = 0;
  endtask

  initial begin
    // reset state
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // reset mid-WB, then a fresh run must start from tile (0,0)
    run_job(3, 2, M_RESET, rel);
    run_job(2, 2, M_IMM, rel);

    // 2x3 immediate: DONE exactly 6*(ROW+5) cycles after first LOAD_REQ
    run_job(2, 3, M_IMM, rel);
    chk("done_latency", 32'(rel), 32'(6 * (ROW + 5)));

    // zero iterations: straight to DONE, busy for one cycle only
    @(posedge clk); #1;
    start = 1'b1; ia_iters = 0; w_iters = 5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done",       32'(done), 1);
    chk("zero_busy",       32'(busy), 1);
    chk("zero_load_valid", 32'(load_valid), 0);
    chk("zero_pe_start",   32'(pe_start), 0);
    @(posedge clk); #1;
    chk("zero_done_after", 32'(done), 0);
    chk("zero_busy_after", 32'(busy), 0);

    run_job(2, 2, M_STALL, rel);
    run_job(2, 1, M_WBTOG, rel);
    run_job(3, 2, M_FINHI, rel);
    for (int k = 0; k < 4; k++)
      run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), M_RAND, rel);
    run_job(1, 1, M_IMM, rel);
    chk("done_latency_1x1", 32'(rel), 32'(ROW + 5));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
